// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SEND  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder. Returns the first set request bit found by
// scanning upward from ptr, wrapping modulo N.
module rr_priority_encoder #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] winner,
  output logic                 valid
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] idx;
  int               sum;

  // Scan from ptr upward and take the first requester found.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    sum    = 0;
    for (int i = 0; i < N; i++) begin
      sum = int'(ptr) + i;
      if (sum >= N) sum = sum - N;
      idx = PTR_W'(sum);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte transmitter among N requesters. Round-robin grant,
// optional per-requester lock for multi-byte messages, and a per-byte
// watchdog so a stalled transmitter releases the arbiter.
//
// state | meaning
// IDLE  | waiting for a request; winner chosen and byte captured here
// ISSUE | one-cycle strobe to uart_tx plus ack to the winner
// SEND  | byte in flight, waiting for i_tx_next or watchdog expiry
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N-1:0]          i_req,
  input  logic [N-1:0]          i_lock,
  input  logic [BYTE_W*N-1:0]   i_data,
  output logic [N-1:0]          o_ack,
  output logic [BYTE_W-1:0]     o_tx_data,
  output logic                  o_tx_ready,
  input  logic                  i_tx_next,
  output logic                  o_busy,
  output logic [$clog2(N)-1:0]  o_owner,
  output logic                  o_timeout
);

  localparam int PTR_W = $clog2(N);
  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_t        state;
  logic              lock_flag;
  logic [PTR_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  cnt;

  logic [PTR_W-1:0]  rr_winner;
  logic              rr_valid;
  logic              lock_hold;
  logic [PTR_W-1:0]  win_idx;
  logic              win_valid;
  logic [BYTE_W-1:0] win_data;
  logic [PTR_W-1:0]  next_ptr;
  logic              expire;

  rr_priority_encoder #(.N(N)) u_rr (
    .req    (i_req),
    .ptr    (rr_ptr),
    .winner (rr_winner),
    .valid  (rr_valid)
  );

  // A locked owner keeps the transmitter only while it still requests.
  assign lock_hold = lock_flag && i_req[o_owner];
  assign win_idx   = lock_hold ? o_owner : rr_winner;
  assign win_valid = lock_hold || rr_valid;
  assign next_ptr  = (o_owner == PTR_W'(N - 1)) ? '0 : o_owner + PTR_W'(1);

  // The counter is 0 in the first SEND cycle; expiring as it would step to
  // TIMEOUT-1 places the o_timeout pulse exactly TIMEOUT cycles after ISSUE.
  assign expire = (cnt == CNT_W'(TIMEOUT - 2));

  // Select the winner's byte slice.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < N; k++) begin
      if (win_idx == PTR_W'(k)) win_data = i_data[k*BYTE_W +: BYTE_W];
    end
  end

  // Arbitration FSM with registered strobes, ownership and watchdog.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      lock_flag  <= 1'b0;
      rr_ptr     <= '0;
      cnt        <= '0;
      o_ack      <= '0;
      o_tx_data  <= '0;
      o_tx_ready <= 1'b0;
      o_busy     <= 1'b0;
      o_owner    <= '0;
      o_timeout  <= 1'b0;
    end else begin
      o_ack      <= '0;
      o_tx_ready <= 1'b0;
      o_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (!lock_hold) lock_flag <= 1'b0;
          if (win_valid) begin
            o_tx_data  <= win_data;
            o_owner    <= win_idx;
            o_ack      <= N'(1) << win_idx;
            o_tx_ready <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt    <= '0;
          o_busy <= 1'b1;
          state  <= SEND;
        end
        SEND: begin
          if (i_tx_next) begin
            o_busy    <= 1'b0;
            lock_flag <= i_lock[o_owner];
            if (!i_lock[o_owner]) rr_ptr <= next_ptr;
            state     <= IDLE;
          end else if (expire) begin
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            lock_flag <= 1'b0;
            rr_ptr    <= next_ptr;
            state     <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a
// randomized run, all compared every cycle against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, lock;
  logic [31:0] data;
  logic        tx_next;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_ready, busy, timeout_p;
  logic [1:0]  owner;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_lock     (lock),
    .i_data     (data),
    .o_ack      (ack),
    .o_tx_data  (tx_data),
    .o_tx_ready (tx_ready),
    .i_tx_next  (tx_next),
    .o_busy     (busy),
    .o_owner    (owner),
    .o_timeout  (timeout_p)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model: free means the arbiter may grant at the next edge; age counts edges
  // since the grant edge
  bit         m_free;
  bit         m_lock;
  int         m_owner, m_ptr, m_gedge, m_resp;
  logic [3:0] e_ack;
  logic [7:0] e_data;
  logic [1:0] e_owner;
  logic       e_ready, e_busy, e_timeout;

  bit   rand_mode = 0;
  bit   spur = 0;
  int   resp_q[$];
  int   dut_g[$], dut_d[$], dut_rc[$], mod_g[$], mod_d[$];
  logic busy_h[int];
  int   n_to, to_cyc, txn_cyc, n2, ii;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_seq(string nm, int act[$], logic [63:0] exp, int n);
    chk({nm, "_len"}, act.size(), n);
    for (int i = 0; i < n && i < act.size(); i++) chk(nm, act[i], exp[8*i +: 8]);
  endtask

  task automatic model_reset();
    m_free = 1; m_lock = 0; m_ptr = 0; m_owner = 0; m_resp = -1;
    e_ack = 0; e_data = 0; e_owner = 0; e_ready = 0; e_busy = 0; e_timeout = 0;
  endtask

  task automatic model_edge();
    int w, age;
    e_ready = 0; e_ack = 0; e_timeout = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_free) begin
      w = -1;
      if (m_lock && req[m_owner]) w = m_owner;
      else begin
        m_lock = 0;
        for (int i = 0; i < N; i++)
          if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      end
      if (w >= 0) begin
        m_free = 0; m_gedge = cyc; m_owner = w;
        e_owner = 2'(w); e_data = data[8*w +: 8];
        e_ready = 1; e_ack = 4'(1) << w;
      end
    end else begin
      age = cyc - m_gedge;
      if (age == 1) e_busy = 1;
      else if (tx_next || age == TO) begin
        e_busy = 0; m_free = 1;
        if (tx_next) m_lock = lock[m_owner];
        else begin m_lock = 0; e_timeout = 1; end
        if (!m_lock) m_ptr = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    chk("ack", ack, e_ack);
    chk("tx_ready", tx_ready, e_ready);
    chk("tx_data", tx_data, e_data);
    chk("owner", owner, e_owner);
    chk("busy", busy, e_busy);
    chk("timeout", timeout_p, e_timeout);
    busy_h[cyc] = busy;
    if (tx_ready) begin
      dut_g.push_back(int'(owner)); dut_d.push_back(int'(tx_data)); dut_rc.push_back(cyc);
    end
    if (timeout_p) begin n_to++; to_cyc = cyc; end
    if (e_ready) begin
      mod_g.push_back(int'(e_owner)); mod_d.push_back(int'(e_data));
      if (resp_q.size() > 0) m_resp = resp_q.pop_front();
      else m_resp = rand_mode ? int'($urandom_range(0, 9)) : 3;
    end
    tx_next = (!m_free && m_resp >= 0 && cyc == m_gedge + m_resp) || spur;
    spur = 0;
    if (tx_next) txn_cyc = cyc;
  endtask

  task automatic do_reset(int n);
    rst = 1;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout", timeout_p, 0);
    for (int i = 0; i < n; i++) cycle();
    rst = 0;
    dut_g.delete(); dut_d.delete(); dut_rc.delete(); mod_g.delete(); mod_d.delete();
    resp_q.delete(); n_to = 0; m_resp = -1;
  endtask

  task automatic run_grants(int n, int budget);
    for (int b = 0; b < budget && mod_g.size() < n; b++) cycle();
    chk("grant_budget", mod_g.size(), n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 0; req = 0; lock = 0; data = 0; tx_next = 0;
    model_reset();
    #2;

    // reset with all four requesting, then plain round robin
    req = 4'b1111; data = 32'h43_32_21_10;
    do_reset(3);
    run_grants(5, 100);
    chk_seq("t1_grant", dut_g, 64'h00_03_02_01_00, 5);
    chk_seq("t1_grant_model", mod_g, 64'h00_03_02_01_00, 5);
    chk_seq("t1_data", dut_d, 64'h10_43_32_21_10, 5);
    chk_seq("t1_data_model", mod_d, 64'h10_43_32_21_10, 5);

    // locked three-byte message from requester 2 with 0 and 3 waiting
    req = 0; lock = 0;
    do_reset(2);
    req = 4'b0100; lock = 4'b0100; data = 32'h3A_AA_55_0A; n2 = 0;
    for (int b = 0; b < 300 && mod_g.size() < 5; b++) begin
      cycle();
      if (e_ack[2]) begin
        n2++;
        if (n2 == 1) begin req[0] = 1; req[3] = 1; end
        if (n2 == 3) begin req[2] = 0; lock[2] = 0; end
      end
      if (e_ack[3]) req[3] = 0;
      if (e_ack[0]) req[0] = 0;
    end
    chk_seq("t2_grant", dut_g, 64'h00_03_02_02_02, 5);
    chk_seq("t2_grant_model", mod_g, 64'h00_03_02_02_02, 5);
    chk_seq("t2_data", dut_d, 64'h0A_3A_AA_AA_AA, 5);

    // completion five cycles after ISSUE, then back-to-back gap
    req = 0; lock = 0;
    do_reset(2);
    req = 4'b0011; data = 32'h00_00_66_55;
    resp_q.push_back(5);
    run_grants(2, 100);
    chk("t3_ready_count", dut_rc.size(), 2);
    if (dut_rc.size() >= 2) begin
      ii = dut_rc[0];
      chk("t3_busy_before", busy_h[ii + 5], 1);
      chk("t3_busy_after", busy_h[ii + 6], 0);
      chk("t3_gap", dut_rc[1] - txn_cyc, 2);
    end
    chk_seq("t3_grant", dut_g, 64'h01_00, 2);

    // watchdog expiry on a locked owner hands over to the next requester
    req = 0; lock = 0;
    do_reset(2);
    req = 4'b0110; lock = 4'b0010; data = 32'h00_C2_B1_00;
    resp_q.push_back(3); resp_q.push_back(-1); resp_q.push_back(3);
    run_grants(3, 200);
    chk_seq("t4_grant", dut_g, 64'h02_01_01, 3);
    chk("t4_timeouts", n_to, 1);
    if (dut_rc.size() >= 2) chk("t4_timeout_delay", to_cyc - dut_rc[1], 8);

    // spurious tx_next in IDLE, then completion coincident with expiry
    req = 0; lock = 0;
    do_reset(2);
    spur = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_spur_busy", busy, 0);
    chk("t5_spur_grants", dut_g.size(), 0);
    req = 4'b0001; data = 32'h00_00_00_5E;
    resp_q.push_back(7);
    run_grants(1, 20);
    for (int i = 0; i < 10; i++) cycle();
    chk("t5_no_timeout", n_to, 0);
    if (dut_rc.size() >= 1) begin
      ii = dut_rc[0];
      chk("t5_busy_last", busy_h[ii + 7], 1);
      chk("t5_busy_done", busy_h[ii + 8], 0);
    end
    chk("t5_regrant", dut_rc.size() >= 2, 1);

    // reset in the middle of a locked message
    req = 0; lock = 0;
    do_reset(2);
    req = 4'b0010; data = 32'h00_00_21_70;
    resp_q.push_back(3); resp_q.push_back(3); resp_q.push_back(-1);
    for (int b = 0; b < 200 && mod_g.size() < 3; b++) begin
      cycle();
      if (e_ack[1]) begin req = 4'b0001; lock = 4'b0001; end
    end
    for (int i = 0; i < 3; i++) cycle();
    chk("t6_busy_mid", busy, 1);
    chk_seq("t6_pre", dut_g, 64'h00_00_01, 3);
    req = 4'b1111; lock = 0; data = 32'h43_32_21_10;
    do_reset(2);
    run_grants(1, 20);
    chk_seq("t6_after", dut_g, 64'h00, 1);

    // randomized traffic, locks, stalls, spurious pulses and resets
    req = 0; lock = 0;
    do_reset(2);
    rand_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      spur = ($urandom_range(0, 19) == 0);
      cycle();
      for (int k = 0; k < N; k++) begin
        if (e_ack[k]) begin
          if ($urandom_range(0, 1) == 1) req[k] = 0;
          else data[8*k +: 8] = 8'($urandom);
        end else if (!req[k] && $urandom_range(0, 3) == 0) begin
          req[k] = 1;
          data[8*k +: 8] = 8'($urandom);
        end
      end
      lock = 4'($urandom);
      if ($urandom_range(0, 599) == 0) do_reset(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
